// File: rtl/ram_arb_pkg.sv
// Shared types and the rotated first-one search for the RAM port arbiter.
// The search covers up to CMaxPorts requesters.
package ram_arb_pkg;

  localparam int CMaxPorts = 8;

  typedef enum logic {
    ARB_FREE,
    ARB_LOCKED
  } arbState_t;

  typedef struct packed {
    logic       vld;
    logic [2:0] idx;
  } pick_t;

  function automatic pick_t rrFirst(
    input logic [CMaxPorts-1:0] act,
    input logic [2:0]           ptr,
    input logic [3:0]           cnt
  );
    logic [2*CMaxPorts-1:0] dbl;
    logic [3:0]             j;
    pick_t                  r;
    dbl = {{CMaxPorts{1'b0}}, act}
        | ({{CMaxPorts{1'b0}}, act} << cnt);
    r = '0;
    // Walk downward so the closest port after ptr wins.
    for (int k = CMaxPorts; k >= 1; k--) begin
      j = 4'(ptr) + 4'(k);
      if (4'(k) <= cnt && dbl[j]) begin
        r.vld = 1'b1;
        r.idx = (j >= cnt) ? 3'(j - cnt) : 3'(j);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ram_arb_if.sv
// Requester-side and RAM-side bundle of the shared RAM arbiter.
// slave is the arbiter view, master the requester/RAM view.
interface ram_arb_if #(
  parameter int CAddrLen = 13,
  parameter int CDataLen = 128,
  parameter int CPortCnt = 4
);

  logic [CPortCnt-1:0]          AReqRd;
  logic [CPortCnt-1:0]          AReqWr;
  logic [CPortCnt-1:0]          AReqLock;
  logic [CPortCnt*CAddrLen-1:0] AReqAddr;
  logic [CPortCnt*CDataLen-1:0] AReqMosi;
  logic [CPortCnt-1:0]          AReqGnt;
  logic [CPortCnt-1:0]          ARdVld;
  logic [CDataLen-1:0]          ARdData;
  logic [CAddrLen-1:0]          ARamAddr;
  logic [CDataLen-1:0]          ARamMosi;
  logic                         ARamWrEn;
  logic                         ARamRdEn;
  logic [CDataLen-1:0]          ARamMiso;

  modport slave (
    input  AReqRd, AReqWr, AReqLock,
    input  AReqAddr, AReqMosi, ARamMiso,
    output AReqGnt, ARdVld, ARdData,
    output ARamAddr, ARamMosi,
    output ARamWrEn, ARamRdEn
  );

  modport master (
    output AReqRd, AReqWr, AReqLock,
    output AReqAddr, AReqMosi, ARamMiso,
    input  AReqGnt, ARdVld, ARdData,
    input  ARamAddr, ARamMosi,
    input  ARamWrEn, ARamRdEn
  );

endinterface

// File: rtl/ram_arb_rr_pick.sv
// Combinational round-robin picker: one-hot grant of the first
// active port after APtr, reusable by other shared-RAM controllers.
module ram_arb_rr_pick
  import ram_arb_pkg::*;
#(
  parameter  int CPortCnt = 4,
  localparam int CPtrLen  = $clog2(CPortCnt)
) (
  input  logic [CPortCnt-1:0] AAct,
  input  logic [CPtrLen-1:0]  APtr,
  output logic [CPortCnt-1:0] AGnt,
  output logic [CPtrLen-1:0]  AIdx,
  output logic                AVld
);

  pick_t pick;

  always_comb begin
    pick = rrFirst(CMaxPorts'(AAct), 3'(APtr), 4'(CPortCnt));
    AVld = pick.vld;
    AIdx = CPtrLen'(pick.idx);
    AGnt = '0;
    if (pick.vld) AGnt[AIdx] = 1'b1;
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter in front of one single-port synchronous RAM.
// Define RAM_ARB_LOCK_EN to add bounded lock bursts.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int CAddrLen = 13,
  parameter int CDataLen = 128,
  parameter int CPortCnt = 4,
  parameter int CLockMax = 16
) (
  input  logic      AClkH,
  input  logic      AResetH,
  input  logic      AClkHEn,
  ram_arb_if.slave  ABus
);

  localparam int CPtrLen = $clog2(CPortCnt);

  logic [CPortCnt-1:0] act;
  logic [CPortCnt-1:0] elig;
  logic [CPortCnt-1:0] pickGnt;
  logic [CPortCnt-1:0] gnt;
  logic [CPortCnt-1:0] rdTag;
  logic [CPtrLen-1:0]  ptr;
  logic [CPtrLen-1:0]  pickIdx;
  logic                pickVld;
  logic                go;

  assign act = ABus.AReqRd | ABus.AReqWr;
  assign go  = AClkHEn & ~AResetH & pickVld;

`ifdef RAM_ARB_LOCK_EN
  localparam int CCntLen = $clog2(CLockMax + 1);

  arbState_t           state;
  arbState_t           stateNxt;
  logic [CPtrLen-1:0]  owner;
  logic [CPtrLen-1:0]  ownerNxt;
  logic [CCntLen-1:0]  lockCnt;
  logic [CCntLen-1:0]  lockCntNxt;
  logic                ownerOn;

  assign ownerOn = act[owner] & ABus.AReqLock[owner];

  always_comb begin
    elig = act;
    if (state == ARB_LOCKED)
      elig = ownerOn ? (CPortCnt'(1) << owner) : '0;
  end

  always_comb begin
    stateNxt   = state;
    ownerNxt   = owner;
    lockCntNxt = lockCnt;
    if (AClkHEn) begin
      unique case (state)
        ARB_FREE: begin
          if (go && ABus.AReqLock[pickIdx]) begin
            ownerNxt   = pickIdx;
            lockCntNxt = CCntLen'(1);
            stateNxt   = (CLockMax > 1) ? ARB_LOCKED : ARB_FREE;
          end
        end
        ARB_LOCKED: begin
          if (!ownerOn) begin
            stateNxt = ARB_FREE;
          end else begin
            if (lockCnt != CCntLen'(CLockMax))
              lockCntNxt = lockCnt + 1'b1;
            // This grant reaches CLockMax: it is the last one.
            if (lockCnt >= CCntLen'(CLockMax - 1))
              stateNxt = ARB_FREE;
          end
        end
        default: stateNxt = ARB_FREE;
      endcase
    end
  end

  always_ff @(posedge AClkH) begin
    if (AResetH) begin
      state   <= ARB_FREE;
      owner   <= '0;
      lockCnt <= '0;
    end else begin
      state   <= stateNxt;
      owner   <= ownerNxt;
      lockCnt <= lockCntNxt;
    end
  end
`else
  assign elig = act;
`endif

  ram_arb_rr_pick #(
    .CPortCnt (CPortCnt)
  ) uPick (
    .AAct (elig),
    .APtr (ptr),
    .AGnt (pickGnt),
    .AIdx (pickIdx),
    .AVld (pickVld)
  );

  assign gnt = go ? pickGnt : '0;

  always_ff @(posedge AClkH) begin
    if (AResetH) begin
      ptr   <= CPtrLen'(CPortCnt - 1);
      rdTag <= '0;
    end else if (AClkHEn) begin
      if (go) ptr <= pickIdx;
      rdTag <= gnt & ABus.AReqRd;
    end
  end

  assign ABus.AReqGnt = gnt;
  assign ABus.ARdVld  = AResetH ? '0 : rdTag;
  assign ABus.ARdData = ABus.ARamMiso;

  always_comb begin
    ABus.ARamAddr = '0;
    ABus.ARamMosi = '0;
    ABus.ARamWrEn = 1'b0;
    ABus.ARamRdEn = 1'b0;
    if (go) begin
      ABus.ARamAddr = ABus.AReqAddr[pickIdx*CAddrLen +: CAddrLen];
      ABus.ARamMosi = ABus.AReqMosi[pickIdx*CDataLen +: CDataLen];
      ABus.ARamWrEn = ABus.AReqWr[pickIdx];
      ABus.ARamRdEn = ABus.AReqRd[pickIdx];
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter with a behavioural RAM
// and a read-data scoreboard.
module tb_ram_port_arbiter;

  localparam int AW = 13;
  localparam int DW = 128;
  localparam int PN = 4;
  localparam int LM = 4;

  typedef struct {
    int          port;
    logic [DW-1:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic en;
  int   errs = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   monOn = 1'b0;
  exp_t sbq[$];
  exp_t e;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always #5 clk = ~clk;

  ram_arb_if #(.CAddrLen(AW), .CDataLen(DW), .CPortCnt(PN)) bus();

  ram_port_arbiter #(
    .CAddrLen (AW),
    .CDataLen (DW),
    .CPortCnt (PN),
    .CLockMax (LM)
  ) dut (
    .AClkH   (clk),
    .AResetH (rst),
    .AClkHEn (en),
    .ABus    (bus)
  );

  // Single-port RAM: read-before-write, output held when not reading.
  always @(posedge clk) begin
    if (bus.ARamRdEn) bus.ARamMiso <= mem[bus.ARamAddr];
    if (bus.ARamWrEn) mem[bus.ARamAddr] <= bus.ARamMosi;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (monOn) begin
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        e = sbq.pop_front();
        checks++;
        if (bus.ARdVld !== 4'(1 << e.port) || bus.ARdData !== e.data) begin
          errs++;
          $display("FAIL rd_sb port%0d: vld=%b data=%h want vld=%b data=%h",
                   e.port, bus.ARdVld, bus.ARdData, 4'(1 << e.port), e.data);
        end
      end else begin
        checks++;
        if (bus.ARdVld !== '0) begin
          errs++;
          $display("FAIL rd_unexp: vld=%b want 0000", bus.ARdVld);
        end
      end
    end
  end

  function automatic logic [DW-1:0] dat(int i);
    return {96'h0, 32'hC0DE0000 + 32'(i)};
  endfunction

  task automatic clr();
    bus.AReqRd   = '0;
    bus.AReqWr   = '0;
    bus.AReqLock = '0;
    bus.AReqAddr = '0;
    bus.AReqMosi = '0;
  endtask

  task automatic setp(int p, bit r, bit w, bit l,
                      logic [AW-1:0] a, logic [DW-1:0] d);
    bus.AReqRd[p]   = r;
    bus.AReqWr[p]   = w;
    bus.AReqLock[p] = l;
    bus.AReqAddr[p*AW +: AW] = a;
    bus.AReqMosi[p*DW +: DW] = d;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    clr();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b1;
    clr();
    bus.AReqRd = '1;
    bus.AReqWr = '1;
    #1;
    checks++;
    if (bus.AReqGnt !== '0) begin
      errs++;
      $display("FAIL rst_gnt: got %b want 0000", bus.AReqGnt);
    end
    checks++;
    if ({bus.ARamRdEn, bus.ARamWrEn} !== 2'b00 || bus.ARamAddr !== '0
        || bus.ARamMosi !== '0) begin
      errs++;
      $display("FAIL rst_ram: rd=%b wr=%b addr=%h want all 0",
               bus.ARamRdEn, bus.ARamWrEn, bus.ARamAddr);
    end
    checks++;
    if (bus.ARdVld !== '0) begin
      errs++;
      $display("FAIL rst_vld: got %b want 0000", bus.ARdVld);
    end
    @(negedge clk);
    clr();
    rst = 1'b0;
    monOn = 1'b1;
  endtask

  task automatic test_single_read();
    @(negedge clk);
    setp(2, 0, 1, 0, 13'h010, dat(2));
    #1;
    checks++;
    if (bus.AReqGnt !== 4'b0100 || bus.ARamWrEn !== 1'b1) begin
      errs++;
      $display("FAIL sr_wr: gnt=%b wr=%b want 0100 1", bus.AReqGnt, bus.ARamWrEn);
    end
    @(negedge clk);
    clr();
    setp(2, 1, 0, 0, 13'h010, '0);
    #1;
    checks++;
    if (bus.AReqGnt !== 4'b0100 || bus.ARamRdEn !== 1'b1
        || bus.ARamWrEn !== 1'b0 || bus.ARamAddr !== 13'h010) begin
      errs++;
      $display("FAIL sr_rd: gnt=%b rd=%b wr=%b addr=%h want 0100 1 0 010",
               bus.AReqGnt, bus.ARamRdEn, bus.ARamWrEn, bus.ARamAddr);
    end
    sbq.push_back('{2, dat(2), cyc + 1});
    @(negedge clk);
    clr();
  endtask

  task automatic test_round_robin();
    int wt [PN];
    int maxWt;
    int want;
    doReset();
    maxWt = 0;
    for (int i = 0; i < PN; i++) wt[i] = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0)
        for (int i = 0; i < PN; i++) setp(i, 0, 1, 0, 13'(13'h100 + i), dat(i));
      #1;
      want = k % PN;
      checks++;
      if (bus.AReqGnt !== 4'(1 << want) || bus.ARamWrEn !== 1'b1
          || bus.ARamAddr !== 13'(13'h100 + want) || bus.ARamMosi !== dat(want)) begin
        errs++;
        $display("FAIL rr_k%0d: gnt=%b addr=%h want %b %h",
                 k, bus.AReqGnt, bus.ARamAddr, 4'(1 << want), 13'(13'h100 + want));
      end
      for (int i = 0; i < PN; i++) begin
        if (bus.AReqGnt[i]) wt[i] = 0;
        else wt[i]++;
        if (wt[i] > maxWt) maxWt = wt[i];
      end
    end
    checks++;
    if (maxWt > PN - 1) begin
      errs++;
      $display("FAIL rr_wait: got %0d want <= %0d", maxWt, PN - 1);
    end
    @(negedge clk);
    clr();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < PN; k++) begin
      @(negedge clk);
      setp(0, 1, 0, 0, 13'(13'h100 + k), '0);
      #1;
      checks++;
      if (bus.AReqGnt !== 4'b0001 || bus.ARamAddr !== 13'(13'h100 + k)) begin
        errs++;
        $display("FAIL b2b_k%0d: gnt=%b addr=%h want 0001 %h",
                 k, bus.AReqGnt, bus.ARamAddr, 13'(13'h100 + k));
      end
      sbq.push_back('{0, dat(k), cyc + 1});
    end
    @(negedge clk);
    clr();
  endtask

  task automatic test_rmw();
    @(negedge clk);
    setp(1, 0, 1, 0, 13'h005, 128'h55);
    #1;
    checks++;
    if (bus.AReqGnt !== 4'b0010) begin
      errs++;
      $display("FAIL rmw_pre: gnt=%b want 0010", bus.AReqGnt);
    end
    @(negedge clk);
    setp(1, 1, 1, 0, 13'h005, 128'hAA);
    #1;
    checks++;
    if (bus.AReqGnt !== 4'b0010 || bus.ARamRdEn !== 1'b1
        || bus.ARamWrEn !== 1'b1 || bus.ARamMosi !== 128'hAA) begin
      errs++;
      $display("FAIL rmw_cmd: gnt=%b rd=%b wr=%b want 0010 1 1",
               bus.AReqGnt, bus.ARamRdEn, bus.ARamWrEn);
    end
    sbq.push_back('{1, 128'h55, cyc + 1});
    @(negedge clk);
    setp(1, 1, 0, 0, 13'h005, '0);
    #1;
    checks++;
    if (bus.AReqGnt !== 4'b0010 || bus.ARamWrEn !== 1'b0) begin
      errs++;
      $display("FAIL rmw_rd: gnt=%b wr=%b want 0010 0", bus.AReqGnt, bus.ARamWrEn);
    end
    sbq.push_back('{1, 128'hAA, cyc + 1});
    @(negedge clk);
    clr();
  endtask

  task automatic test_clk_en();
    @(negedge clk);
    setp(0, 0, 1, 0, 13'h020, dat(20));
    setp(1, 0, 1, 0, 13'h021, dat(21));
    #1;
    checks++;
    if (bus.AReqGnt !== 4'b0001) begin
      errs++;
      $display("FAIL ce_pre: gnt=%b want 0001", bus.AReqGnt);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      en = 1'b0;
      #1;
      checks++;
      if (bus.AReqGnt !== '0 || bus.ARamWrEn !== 1'b0 || bus.ARamRdEn !== 1'b0) begin
        errs++;
        $display("FAIL ce_off%0d: gnt=%b wr=%b rd=%b want 0000 0 0",
                 k, bus.AReqGnt, bus.ARamWrEn, bus.ARamRdEn);
      end
    end
    @(negedge clk);
    en = 1'b1;
    #1;
    checks++;
    if (bus.AReqGnt !== 4'b0010) begin
      errs++;
      $display("FAIL ce_resume: gnt=%b want 0010", bus.AReqGnt);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.AReqGnt !== 4'b0001) begin
      errs++;
      $display("FAIL ce_next: gnt=%b want 0001", bus.AReqGnt);
    end
    @(negedge clk);
    clr();
  endtask

  task automatic test_lock();
    int seq [6];
`ifdef RAM_ARB_LOCK_EN
    seq = '{3, 3, 3, 0, 3, 3};
`else
    seq = '{0, 3, 0, 3, 0, 3};
`endif
    doReset();
    @(negedge clk);
    setp(3, 0, 1, 1, 13'h030, dat(30));
    #1;
    checks++;
    if (bus.AReqGnt !== 4'b1000) begin
      errs++;
      $display("FAIL lk_first: gnt=%b want 1000", bus.AReqGnt);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) setp(0, 0, 1, 0, 13'h031, dat(31));
      #1;
      checks++;
      if (bus.AReqGnt !== 4'(1 << seq[k])) begin
        errs++;
        $display("FAIL lk_k%0d: gnt=%b want %b", k, bus.AReqGnt, 4'(1 << seq[k]));
      end
    end
    @(negedge clk);
    clr();
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    setp(1, 1, 0, 0, 13'h010, '0);
    #1;
    checks++;
    if (bus.AReqGnt !== 4'b0010) begin
      errs++;
      $display("FAIL rm_gnt: gnt=%b want 0010", bus.AReqGnt);
    end
    @(negedge clk);
    rst = 1'b1;
    clr();
    for (int i = 0; i < PN; i++) setp(i, 1, 0, 0, 13'h010, '0);
    #1;
    checks++;
    if (bus.ARdVld !== '0 || bus.AReqGnt !== '0) begin
      errs++;
      $display("FAIL rm_vld: vld=%b gnt=%b want 0000 0000", bus.ARdVld, bus.AReqGnt);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.AReqGnt !== 4'b0001) begin
      errs++;
      $display("FAIL rm_after: gnt=%b want 0001", bus.AReqGnt);
    end
    sbq.push_back('{0, dat(2), cyc + 1});
    @(negedge clk);
    clr();
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    clr();
    test_reset();
    test_single_read();
    test_round_robin();
    test_back_to_back();
    test_rmw();
    test_clk_en();
    test_lock();
    test_reset_mid_read();
    repeat (3) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      errs++;
      $display("FAIL sb_drain: %0d left want 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
